// File: rtl/sipo_frame_receiver.sv
// Serial-in, word-out frame receiver with a valid/ready holding register.
// It also detects overrun, frames aborted by resync, and inter-bit timeouts.
`timescale 1ns/1ps
module sipo_frame_receiver #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned TIMEOUT   = 16,
  localparam int unsigned CNT_W    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             s_in,
  input  logic             s_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  output logic             frame_error
);

  localparam int unsigned IDL_W = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d, sr_next;
  logic [IDL_W-1:0]   idle_q, idle_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               ferr_q, ferr_d;
  logic               timeout_hit;

  // State registers; all outputs come straight from these flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: clear > frame_start > timeout > s_valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    idle_d  = idle_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    ferr_d  = 1'b0;

    sr_next = (MSB_FIRST != 0) ? {sr_q[WIDTH-2:0], s_in} : {s_in, sr_q[WIDTH-1:1]};
    // The idle count would reach TIMEOUT on this edge; discard here so the
    // pulse follows the TIMEOUT-th idle cycle directly.
    timeout_hit = (TIMEOUT != 0) && (state_q == RECV) && !s_valid &&
                  (idle_q == IDL_W'(TIMEOUT - 1));

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      sr_d    = '0;
      idle_d  = '0;
      data_d  = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      if (valid_q && data_ready) begin
        valid_d = 1'b0;
      end

      if (frame_start) begin
        ferr_d = (state_q == RECV);
        idle_d = '0;
        if (s_valid) begin
          sr_d    = sr_next;
          cnt_d   = CNT_W'(1);
          state_d = RECV;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end else if (timeout_hit) begin
        cnt_d   = '0;
        idle_d  = '0;
        state_d = IDLE;
        ferr_d  = 1'b1;
      end else if (s_valid) begin
        sr_d   = sr_next;
        idle_d = '0;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          // Holding register is free if empty or being drained this cycle.
          if (!valid_q || data_ready) begin
            data_d  = sr_next;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = RECV;
        end
      end else if ((state_q == RECV) && (TIMEOUT != 0)) begin
        idle_d = idle_q + IDL_W'(1);
      end
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign busy        = (state_q == RECV);
  assign bit_count   = cnt_q;
  assign overrun     = ovr_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_sipo_frame_receiver.sv
// Directed bench for sipo_frame_receiver: MSB-first and LSB-first instances
// share one stimulus stream; expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_sipo_frame_receiver;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset_n, clear, s_in, s_valid, frame_start, data_ready;
  logic [W-1:0]  data_m, data_l;
  logic          valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, ferr_m, ferr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  sipo_frame_receiver #(.WIDTH(W), .MSB_FIRST(1), .TIMEOUT(4)) u_msb (
    .clk(clk), .reset_n(reset_n), .clear(clear), .s_in(s_in), .s_valid(s_valid),
    .frame_start(frame_start), .data(data_m), .data_valid(valid_m),
    .data_ready(data_ready), .busy(busy_m), .bit_count(cnt_m),
    .overrun(ovr_m), .frame_error(ferr_m)
  );

  sipo_frame_receiver #(.WIDTH(W), .MSB_FIRST(0), .TIMEOUT(4)) u_lsb (
    .clk(clk), .reset_n(reset_n), .clear(clear), .s_in(s_in), .s_valid(s_valid),
    .frame_start(frame_start), .data(data_l), .data_valid(valid_l),
    .data_ready(data_ready), .busy(busy_l), .bit_count(cnt_l),
    .overrun(ovr_l), .frame_error(ferr_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 ns after the edge.
  task automatic step(input logic sin, input logic sv, input logic fs, input logic rdy);
    s_in        = sin;
    s_valid     = sv;
    frame_start = fs;
    data_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    for (int i = 7; i >= 0; i--) step(b[i], 1'b1, 1'b0, rdy);
  endtask

  initial begin
    logic [7:0] pat;
    reset_n = 1'b0; clear = 1'b0; s_in = 1'b0; s_valid = 1'b0;
    frame_start = 1'b0; data_ready = 1'b1;
    #1;
    chk("rst_data",  32'(data_m),  32'h0);
    chk("rst_valid", 32'(valid_m), 32'h0);
    chk("rst_busy",  32'(busy_m),  32'h0);
    chk("rst_cnt",   32'(cnt_m),   32'h0);
    chk("rst_ovr",   32'(ovr_m),   32'h0);
    chk("rst_ferr",  32'(ferr_m),  32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Stream 0,0,0,1,1,1,1,0 with consumer always ready.
    pat = 8'b0001_1110;
    for (int i = 7; i >= 1; i--) step(pat[i], 1'b1, 1'b0, 1'b1);
    chk("t1_cnt7",  32'(cnt_m),  32'd7);
    chk("t1_busy7", 32'(busy_m), 32'h1);
    step(pat[0], 1'b1, 1'b0, 1'b1);
    chk("t1_data_msb",  32'(data_m),  32'h1E);
    chk("t1_valid_msb", 32'(valid_m), 32'h1);
    chk("t1_data_lsb",  32'(data_l),  32'h78);
    chk("t1_valid_lsb", 32'(valid_l), 32'h1);
    chk("t1_cnt_wrap",  32'(cnt_m),   32'h0);
    chk("t1_busy_end",  32'(busy_m),  32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1_valid_drop", 32'(valid_m), 32'h0);
    chk("t1_data_hold",  32'(data_m),  32'h1E);

    // Back-to-back frames with no consumer: second word is dropped.
    send_byte(8'hA5, 1'b0);
    chk("t2_data_a5", 32'(data_m),  32'hA5);
    chk("t2_valid1",  32'(valid_m), 32'h1);
    chk("t2_ovr0",    32'(ovr_m),   32'h0);
    send_byte(8'h3C, 1'b0);
    chk("t2_data_kept", 32'(data_m),  32'hA5);
    chk("t2_valid2",    32'(valid_m), 32'h1);
    chk("t2_ovr1",      32'(ovr_m),   32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_consumed",   32'(valid_m), 32'h0);
    chk("t2_ovr_sticky", 32'(ovr_m),   32'h1);
    clear = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    clear = 1'b0;
    chk("t2_clr_ovr",  32'(ovr_m),  32'h0);
    chk("t2_clr_data", 32'(data_m), 32'h0);

    // Inter-bit timeout after 3 bits and 4 idle cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_cnt_before", 32'(cnt_m),  32'd3);
    chk("t3_ferr_early", 32'(ferr_m), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ferr_pulse", 32'(ferr_m), 32'h1);
    chk("t3_cnt_zero",   32'(cnt_m),  32'h0);
    chk("t3_busy_zero",  32'(busy_m), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ferr_single", 32'(ferr_m), 32'h0);
    send_byte(8'h5A, 1'b1);
    chk("t3_data_5a",  32'(data_m),  32'h5A);
    chk("t3_valid_5a", 32'(valid_m), 32'h1);

    // Resync mid-frame with a bit on the same cycle.
    pat = 8'b1010_1000;
    for (int i = 7; i >= 3; i--) step(pat[i], 1'b1, 1'b0, 1'b1);
    chk("t4_cnt5", 32'(cnt_m), 32'd5);
    pat = 8'hC3;
    step(pat[7], 1'b1, 1'b1, 1'b1);
    chk("t4_ferr_pulse", 32'(ferr_m), 32'h1);
    chk("t4_cnt1",       32'(cnt_m),  32'd1);
    step(pat[6], 1'b1, 1'b0, 1'b1);
    chk("t4_ferr_single", 32'(ferr_m), 32'h0);
    chk("t4_cnt2",        32'(cnt_m),  32'd2);
    for (int i = 5; i >= 0; i--) step(pat[i], 1'b1, 1'b0, 1'b1);
    chk("t4_data_c3",  32'(data_m),  32'hC3);
    chk("t4_valid_c3", 32'(valid_m), 32'h1);

    // Async reset mid-frame with a pending word.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_pend_valid", 32'(valid_m), 32'h1);
    chk("t5_cnt4",       32'(cnt_m),   32'd4);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_data",  32'(data_m),  32'h0);
    chk("t5_rst_valid", 32'(valid_m), 32'h0);
    chk("t5_rst_cnt",   32'(cnt_m),   32'h0);
    chk("t5_rst_busy",  32'(busy_m),  32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    send_byte(8'h81, 1'b0);
    chk("t5_data_81", 32'(data_m),  32'h81);
    chk("t5_valid",   32'(valid_m), 32'h1);

    // Completion on the same cycle the pending word is drained.
    pat = 8'h42;
    for (int i = 7; i >= 1; i--) step(pat[i], 1'b1, 1'b0, 1'b0);
    step(pat[0], 1'b1, 1'b0, 1'b1);
    chk("t5_data_42",  32'(data_m),  32'h42);
    chk("t5_valid_42", 32'(valid_m), 32'h1);
    chk("t5_no_ovr",   32'(ovr_m),   32'h0);

    // Resync while idle raises no error.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_fs_idle_ferr", 32'(ferr_m),  32'h0);
    chk("t6_fs_idle_cnt",  32'(cnt_m),   32'h0);
    chk("t6_consumed",     32'(valid_m), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
